fir_output_requantizer: RTL and testbench

- Narrowing counterpart to the FIR sign-extension path: converts the wide signed accumulator result back to the narrow sample width.
- Operation: round half-up, arithmetic right shift by SHIFT, saturate to WIDTH_OF_OUTPUT_DATA.
- Sits between the FIR accumulator and the output sample bus.
- 2-stage elastic pipeline with valid/ready handshakes on both sides; counts saturation events for debug.

---
 rtl/fir_output_requantizer.sv | 109 ++++++++++
 tb/tb_fir_output_requantizer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_output_requantizer.sv
// Requantizes a wide signed FIR accumulator to the narrow output sample width.
// It rounds half-up, shifts arithmetically, saturates, and counts clipped samples delivered.
module fir_output_requantizer #(
    parameter int WIDTH_OF_INPUT_DATA  = 20,
    parameter int WIDTH_OF_OUTPUT_DATA = 8,
    parameter int SHIFT                = 10,
    parameter int COUNT_WIDTH          = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            input_valid,
    output logic                            input_ready,
    input  logic [WIDTH_OF_INPUT_DATA-1:0]  input_data,
    output logic                            output_valid,
    input  logic                            output_ready,
    output logic [WIDTH_OF_OUTPUT_DATA-1:0] output_data,
    output logic                            saturation_flag,
    input  logic                            clear_count,
    output logic [COUNT_WIDTH-1:0]          saturation_count
);

    localparam int WI = WIDTH_OF_INPUT_DATA;
    localparam int WO = WIDTH_OF_OUTPUT_DATA;

    localparam logic        [WI:0] HALF  = (WI+1)'(1) << (SHIFT - 1);
    localparam logic signed [WI:0] MAX_S = {{(WI-WO+2){1'b0}}, {(WO-1){1'b1}}};
    localparam logic signed [WI:0] MIN_S = {{(WI-WO+2){1'b1}}, {(WO-1){1'b0}}};

    logic signed [WI:0]      r1_q, r1_d;
    logic                    v1_q, v1_d;
    logic [WO-1:0]           out_q, out_d;
    logic                    flag_q, flag_d;
    logic                    v2_q, v2_d;
    logic [COUNT_WIDTH-1:0]  cnt_q, cnt_d;

    logic                    adv;
    logic                    in_xfer;
    logic                    out_xfer;
    logic signed [WI:0]      s;

    always_comb begin
        adv         = !v2_q || output_ready;
        input_ready = !rst && (!v1_q || adv);
        in_xfer     = input_valid && input_ready;
        out_xfer    = v2_q && output_ready;
        s           = r1_q >>> SHIFT;

        r1_d   = r1_q;
        v1_d   = v1_q;
        out_d  = out_q;
        flag_d = flag_q;
        v2_d   = v2_q;
        cnt_d  = cnt_q;

        // Stage 1 is free whenever it is empty or hands its sample to stage 2.
        if (!v1_q || adv) begin
            v1_d = in_xfer;
            if (in_xfer) begin
                r1_d = {input_data[WI-1], input_data} + HALF;
            end
        end

        if (adv) begin
            v2_d = v1_q;
            if (v1_q) begin
                if (s > MAX_S) begin
                    out_d  = {1'b0, {(WO-1){1'b1}}};
                    flag_d = 1'b1;
                end else if (s < MIN_S) begin
                    out_d  = {1'b1, {(WO-1){1'b0}}};
                    flag_d = 1'b1;
                end else begin
                    out_d  = s[WO-1:0];
                    flag_d = 1'b0;
                end
            end
        end

        if (clear_count) begin
            cnt_d = '0;
        end else if (out_xfer && flag_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + COUNT_WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r1_q   <= '0;
            v1_q   <= 1'b0;
            out_q  <= '0;
            flag_q <= 1'b0;
            v2_q   <= 1'b0;
            cnt_q  <= '0;
        end else begin
            r1_q   <= r1_d;
            v1_q   <= v1_d;
            out_q  <= out_d;
            flag_q <= flag_d;
            v2_q   <= v2_d;
            cnt_q  <= cnt_d;
        end
    end

    assign output_valid     = v2_q;
    assign output_data      = out_q;
    assign saturation_flag  = flag_q;
    assign saturation_count = cnt_q;

endmodule

// File: tb/tb_fir_output_requantizer.sv
// Randomized and directed bench for fir_output_requantizer against an arithmetic
// reference model with a FIFO scoreboard of expected samples.
module tb_fir_output_requantizer;

    localparam int WI = 20;
    localparam int WO = 8;
    localparam int SH = 10;
    localparam int CW = 4;
    localparam longint CMAX = (64'sd1 <<< CW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          input_valid;
    logic          input_ready;
    logic [WI-1:0] input_data;
    logic          output_valid;
    logic          output_ready;
    logic [WO-1:0] output_data;
    logic          saturation_flag;
    logic          clear_count;
    logic [CW-1:0] saturation_count;

    always #5 clk = ~clk;

    fir_output_requantizer #(
        .WIDTH_OF_INPUT_DATA (WI),
        .WIDTH_OF_OUTPUT_DATA(WO),
        .SHIFT               (SH),
        .COUNT_WIDTH         (CW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .input_valid     (input_valid),
        .input_ready     (input_ready),
        .input_data      (input_data),
        .output_valid    (output_valid),
        .output_ready    (output_ready),
        .output_data     (output_data),
        .saturation_flag (saturation_flag),
        .clear_count     (clear_count),
        .saturation_count(saturation_count)
    );

    typedef struct {
        longint val;
        bit     sat;
    } exp_t;

    int      checks   = 0;
    int      failures = 0;
    exp_t    q[$];
    longint  mcount   = 0;
    bit      hold_prev = 1'b0;
    logic [WO-1:0] prev_d;
    logic    prev_f;
    bit      lat_chk  = 1'b0;
    bit [1:0] acc_hist = '0;

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Round half-up with floor division, then clamp to the output range.
    function automatic exp_t ref_model(input longint x);
        exp_t   e;
        longint t;
        longint y;
        longint den;
        longint hi;
        longint lo;
        den = 64'sd1 <<< SH;
        hi  = (64'sd1 <<< (WO - 1)) - 1;
        lo  = -(64'sd1 <<< (WO - 1));
        t   = x + (den / 2);
        if (t >= 0) y = t / den;
        else        y = -((-t + den - 1) / den);
        e.sat = 1'b0;
        if (y > hi) begin
            y = hi;
            e.sat = 1'b1;
        end else if (y < lo) begin
            y = lo;
            e.sat = 1'b1;
        end
        e.val = y;
        return e;
    endfunction

    task automatic cyc(input bit v, input longint d, input bit r, input bit c, input bit rs,
                       output bit acc);
        exp_t     e;
        bit       out_x;
        logic [63:0] dv;
        @(posedge clk);
        #1;
        dv          = d;
        rst         = rs;
        input_valid = v;
        input_data  = dv[WI-1:0];
        output_ready = r;
        clear_count = c;
        #1;
        if (hold_prev) begin
            check("hold_valid", output_valid, 1);
            check("hold_data", output_data, prev_d);
            check("hold_flag", saturation_flag, prev_f);
        end
        check("count", saturation_count, mcount);
        check("in_ready", input_ready, rs ? 0 : !(q.size() == 2 && !r));
        if (lat_chk) check("latency_valid", output_valid, acc_hist[1]);
        acc   = v && input_ready;
        out_x = output_valid && r;
        e.sat = 1'b0;
        if (out_x) begin
            if (q.size() == 0) begin
                check("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                check("out_data", $signed(output_data), e.val);
                check("out_flag", saturation_flag, e.sat);
            end
        end
        hold_prev = output_valid && !r && !rs;
        prev_d    = output_data;
        prev_f    = saturation_flag;
        if (rs || c)                                mcount = 0;
        else if (out_x && e.sat && mcount < CMAX)   mcount++;
        if (rs) begin
            q.delete();
            acc_hist = '0;
        end else begin
            if (acc) q.push_back(ref_model(d));
            acc_hist = {acc_hist[0], acc};
        end
    endtask

    task automatic send(input longint d, input bit r);
        bit acc;
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 50) begin
            cyc(1'b1, d, r, 1'b0, 1'b0, acc);
            n++;
        end
        check("send_accepted", acc, 1);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
            n++;
        end
        check("drain_empty", q.size(), 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
    endtask

    longint basic_in[5] = '{1024, 1535, 1536, -1536, 0};
    longint sat_in[5]   = '{130047, 130560, 524287, -524288, -131072};

    initial begin
        bit     acc;
        int     k;
        int     ph;
        int     n;
        longint d;

        rst = 1'b1; input_valid = 1'b0; input_data = '0;
        output_ready = 1'b0; clear_count = 1'b0;
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
        check("rst_valid", output_valid, 0);
        check("rst_data", output_data, 0);
        check("rst_flag", saturation_flag, 0);
        check("rst_count", saturation_count, 0);

        // Basic rounding, one sample every third cycle with latency checks.
        lat_chk = 1'b1;
        foreach (basic_in[i]) begin
            send(basic_in[i], 1'b1);
            cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
            cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
        end
        drain();
        lat_chk = 1'b0;

        // Saturation boundaries.
        foreach (sat_in[i]) send(sat_in[i], 1'b1);
        drain();
        check("sat_count_3", saturation_count, 3);

        // Backpressure: output_ready 1,0,0,1 repeating.
        ph = 0;
        k  = 1;
        n  = 0;
        while ((k <= 10 || q.size() > 0) && n < 200) begin
            cyc(k <= 10, 1024 * k, (ph == 0 || ph == 3), 1'b0, 1'b0, acc);
            if (acc) k++;
            ph = (ph + 1) % 4;
            n++;
        end
        check("bp_all_sent", k, 11);
        check("bp_drained", q.size(), 0);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);

        // Full throughput with random data.
        lat_chk = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if ($urandom_range(0, 1) == 0) d = $signed(20'($urandom));
            else d = longint'($urandom_range(0, 262143)) - 131072;
            cyc(1'b1, d, 1'b1, 1'b0, 1'b0, acc);
            check("tp_accept", acc, 1);
        end
        drain();
        lat_chk = 1'b0;

        // Counter sticks at its maximum.
        for (int i = 0; i < 20; i++) send(524287, 1'b1);
        drain();
        check("count_stick", saturation_count, CMAX);

        // Clear wins over a simultaneous saturating transfer.
        cyc(1'b0, 0, 1'b0, 1'b1, 1'b0, acc);
        send(-524288, 1'b0);
        n = 0;
        while (!output_valid && n < 10) begin
            cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
            n++;
        end
        check("clr_out_valid", output_valid, 1);
        cyc(1'b0, 0, 1'b1, 1'b1, 1'b0, acc);
        cyc(1'b0, 0, 1'b1, 1'b0, 1'b0, acc);
        check("clr_wins", saturation_count, 0);

        // Reset with both stages full and stalled.
        send(524287, 1'b1);
        drain();
        send(3072, 1'b0);
        send(-524288, 1'b0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
        check("full_stall_ready", input_ready, 0);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b1, acc);
        cyc(1'b0, 0, 1'b0, 1'b0, 1'b0, acc);
        check("mid_rst_valid", output_valid, 0);
        check("mid_rst_data", output_data, 0);
        check("mid_rst_count", saturation_count, 0);
        lat_chk = 1'b1;
        send(2048, 1'b1);
        drain();
        lat_chk = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

endmodule
